xsim_msg_deframer: RTL

- Consumes the raw per-cycle beat stream from the DPI message sink (src_rdy/beat) and delimits it into framed portal messages for the hardware request demux.
- Header word: method number in [31:16], message length in 32-bit words (header included) in [15:0].
- Admits a message only if the whole message fits in the internal buffer (admission-checked store); otherwise drops it whole, so the sink never sees a truncated message.
- Sits directly downstream of the simulation sink adapter and upstream of the portal request pipe.

---
 rtl/xsim_msg_pkg.sv | 27 ++
 rtl/xsim_beat_fifo.sv | 55 +++++
 rtl/xsim_msg_deframer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/xsim_msg_pkg.sv
// Shared types for the xsim portal message deframer.
// Header word layout: method in [31:16], length in words in [15:0].
package xsim_msg_pkg;

  localparam int MSG_WORD_W = 32;

  typedef struct packed {
    logic [15:0] method;
    logic [15:0] len;
  } msg_hdr_t;

  typedef enum logic [1:0] {
    HDR,
    PAYLOAD,
    DISCARD
  } deframe_state_t;

  // Message length (header included) carried in a header word
  function automatic logic [15:0] hdr_len(
    input logic [MSG_WORD_W-1:0] w
  );
    msg_hdr_t h;
    h = msg_hdr_t'(w);
    return h.len;
  endfunction

endpackage

// File: rtl/xsim_beat_fifo.sv
// Registered synchronous FIFO holding framed beats.
// Head is read from storage; a pushed word appears one cycle later.
module xsim_beat_fifo #(
  parameter  int DEPTH = 32,
  parameter  int W     = 34,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (cnt_q != FULL);
  assign dout    = empty ? '0 : mem_q[rd_q];

  // Storage write; contents need no reset since count gates the head
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/xsim_msg_deframer.sv
// Delimits the DPI beat stream into whole portal messages.
// Define XSIM_DEFRAME_STATS_EN for live msg/drop counters.
module xsim_msg_deframer
  import xsim_msg_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        src_rdy,
  input  logic [31:0] beat,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_first,
  output logic        out_last,
  output logic        overflow,
  output logic        frame_err,
  input  logic        clear_err,
  output logic [31:0] msg_count,
  output logic [15:0] drop_count
);

  deframe_state_t state_q, state_d;
  logic [15:0]    rem_q, rem_d;
  logic           ovf_q, ovf_d;
  logic           ferr_q, ferr_d;

  logic [15:0]    len;
  logic [16:0]    free;
  logic           fits;
  logic           push;
  logic           pop;
  logic           admit;
  logic           drop;
  logic           ferr_set;
  logic [33:0]    din;
  logic [33:0]    dout;
  logic           empty;
  logic [AW:0]    count;

  xsim_beat_fifo #(
    .DEPTH (DEPTH),
    .W     (34)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .empty (empty),
    .count (count)
  );

  // Space check uses registered occupancy; a same-cycle pop is not credited
  assign len  = hdr_len(beat);
  assign free = 17'(DEPTH) - 17'(count);
  assign fits = ({1'b0, len} <= free);

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign out_data  = dout[33:2];
  assign out_first = dout[1];
  assign out_last  = dout[0];
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

  // Framing FSM next state, buffer push and sticky flag updates
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    push     = 1'b0;
    din      = {beat, 2'b00};
    admit    = 1'b0;
    drop     = 1'b0;
    ferr_set = 1'b0;
    if (src_rdy) begin
      unique case (state_q)
        HDR: begin
          if (len == 16'd0) begin
            ferr_set = 1'b1;
          end else if (fits) begin
            push  = 1'b1;
            admit = 1'b1;
            din   = {beat, 1'b1, len == 16'd1};
            if (len > 16'd1) begin
              rem_d   = len - 16'd1;
              state_d = PAYLOAD;
            end
          end else begin
            drop = 1'b1;
            if (len > 16'd1) begin
              rem_d   = len - 16'd1;
              state_d = DISCARD;
            end
          end
        end
        PAYLOAD: begin
          push  = 1'b1;
          din   = {beat, 1'b0, rem_q == 16'd1};
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = HDR;
        end
        DISCARD: begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = HDR;
        end
        default: state_d = HDR;
      endcase
    end
    ovf_d  = drop | (ovf_q & ~clear_err);
    ferr_d = ferr_set | (ferr_q & ~clear_err);
  end

  // FSM, remaining count and sticky flag registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= HDR;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef XSIM_DEFRAME_STATS_EN
  logic [31:0] msg_q;
  logic [15:0] drop_q;

  // Saturating admission and drop counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      msg_q  <= '0;
      drop_q <= '0;
    end else begin
      if (admit && (msg_q != '1))  msg_q  <= msg_q + 1'b1;
      if (drop  && (drop_q != '1)) drop_q <= drop_q + 1'b1;
    end
  end

  assign msg_count  = msg_q;
  assign drop_count = drop_q;
`else
  logic unused_admit;
  assign unused_admit = admit;
  assign msg_count    = '0;
  assign drop_count   = '0;
`endif

endmodule
